// File: rtl/pipelined_opcode_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Purpose  : Shared opcode encodings, control-class bit positions and the
//             5-bit opcode lookup used by the decode stage.
//  Contents : OP_* opcode constants, CLASS_* bit indices, CLASS_W,
//             op_info_t and lookup_op().
//  Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

    localparam int CLASS_W         = 8;
    localparam int CLASS_RTYPE     = 0;
    localparam int CLASS_JUMP      = 1;
    localparam int CLASS_LINK      = 2;
    localparam int CLASS_BRANCH    = 3;
    localparam int CLASS_LOAD      = 4;
    localparam int CLASS_STORE     = 5;
    localparam int CLASS_IMM       = 6;
    localparam int CLASS_WRITES_RD = 7;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    typedef struct packed {
        logic               legal;
        logic [CLASS_W-1:0] cls;
    } op_info_t;

    // Legality and class bits for the low five opcode bits only; the caller
    // is responsible for rejecting wider opcodes with upper bits set.
    function automatic op_info_t lookup_op(input logic [4:0] op);
        op_info_t info;
        info       = '0;
        info.legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                info.cls[CLASS_RTYPE]     = 1'b1;
                info.cls[CLASS_WRITES_RD] = 1'b1;
            end
            OP_J:     info.cls[CLASS_JUMP] = 1'b1;
            OP_BNE:   info.cls[CLASS_BRANCH] = 1'b1;
            OP_JAL: begin
                info.cls[CLASS_JUMP]      = 1'b1;
                info.cls[CLASS_LINK]      = 1'b1;
                info.cls[CLASS_WRITES_RD] = 1'b1;
            end
            OP_JR:    info.cls[CLASS_JUMP] = 1'b1;
            OP_ADDI: begin
                info.cls[CLASS_IMM]       = 1'b1;
                info.cls[CLASS_WRITES_RD] = 1'b1;
            end
            OP_BLT:   info.cls[CLASS_BRANCH] = 1'b1;
            OP_SW: begin
                info.cls[CLASS_STORE]     = 1'b1;
                info.cls[CLASS_IMM]       = 1'b1;
            end
            OP_LW: begin
                info.cls[CLASS_LOAD]      = 1'b1;
                info.cls[CLASS_IMM]       = 1'b1;
                info.cls[CLASS_WRITES_RD] = 1'b1;
            end
            OP_SETX:  info.cls[CLASS_WRITES_RD] = 1'b1;
            OP_BEX:   info.cls[CLASS_BRANCH] = 1'b1;
            default:  info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_opcode_decoder_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : opcode_onehot_decoder
//  Purpose  : Combinational opcode decode into a one-hot select vector, a
//             control-class vector and an illegal flag.
//  Ports    : opcode   in  OP_W        opcode field
//             select   out 2**OP_W     one-hot select, zero when illegal
//             op_class out CLASS_W     control-class bits, zero when illegal
//             illegal  out 1           opcode not in the legal set
//  Revision : 1.0  initial release
// ============================================================================
module opcode_onehot_decoder
    import decode_pkg::*;
#(
    parameter int OP_W  = 5,
    parameter int SEL_W = 2**OP_W
) (
    input  logic [OP_W-1:0]    opcode,
    output logic [SEL_W-1:0]   select,
    output logic [CLASS_W-1:0] op_class,
    output logic               illegal
);

    localparam logic [SEL_W-1:0] c_sel_one = SEL_W'(1);

    logic     w_upper_clear;
    logic     w_legal;
    op_info_t w_info;

    // Only the low five bits carry an encoding; any higher bit set is illegal.
    generate
        if (OP_W > 5) begin : g_wide_opcode
            assign w_upper_clear = ~|opcode[OP_W-1:5];
        end else begin : g_narrow_opcode
            assign w_upper_clear = 1'b1;
        end
    endgenerate

    assign w_info   = lookup_op(opcode[4:0]);
    assign w_legal  = w_info.legal & w_upper_clear;

    assign select   = w_legal ? (c_sel_one << opcode) : '0;
    assign op_class = w_legal ? w_info.cls : '0;
    assign illegal  = ~w_legal;

endmodule
`default_nettype wire

// File: rtl/pipelined_opcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_opcode_decoder
//  Purpose  : Registered decode stage with a 2-entry skid buffer, flush and a
//             saturating illegal-opcode counter.
//  Ports    : clk, rst_n (async, active low), flush
//             in_valid/in_ready/in_insn      upstream handshake
//             out_valid/out_ready/out_insn   downstream handshake
//             out_select, out_class, out_illegal  decoded fields
//             illegal_count                  illegal entries delivered
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_opcode_decoder
    import decode_pkg::*;
#(
    parameter int INSN_W = 32,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSN_W-1:0]    in_insn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSN_W-1:0]    out_insn,
    output logic [2**OP_W-1:0]   out_select,
    output logic [CLASS_W-1:0]   out_class,
    output logic                 out_illegal,
    output logic [CNT_W-1:0]     illegal_count
);

    localparam int SEL_W = 2**OP_W;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Decode ahead of the buffer so both slots hold finished results.
    logic [SEL_W-1:0]   w_sel;
    logic [CLASS_W-1:0] w_cls;
    logic               w_ill;

    opcode_onehot_decoder #(
        .OP_W  (OP_W),
        .SEL_W (SEL_W)
    ) u_dec (
        .opcode   (in_insn[INSN_W-1 -: OP_W]),
        .select   (w_sel),
        .op_class (w_cls),
        .illegal  (w_ill)
    );

    // Slot 0 drives the outputs; slot 1 is the skid entry.
    logic [1:0]         r_state;
    logic               r_in_ready;
    logic [INSN_W-1:0]  r_insn0,  r_insn1;
    logic [SEL_W-1:0]   r_sel0,   r_sel1;
    logic [CLASS_W-1:0] r_cls0,   r_cls1;
    logic               r_ill0,   r_ill1;
    logic [CNT_W-1:0]   r_cnt;

    logic       w_accept;
    logic       w_take;
    logic       w_load0;
    logic       w_load1;
    logic       w_shift;
    logic [1:0] w_state_nxt;

    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_take   = (r_state != c_st_empty) & out_ready;

    always_comb begin
        w_load0     = 1'b0;
        w_load1     = 1'b0;
        w_shift     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: begin
                w_load0     = w_accept;
                w_state_nxt = w_accept ? c_st_one : c_st_empty;
            end
            c_st_one: begin
                if (w_accept && w_take) begin
                    w_load0 = 1'b1;
                end else if (w_accept) begin
                    w_load1     = 1'b1;
                    w_state_nxt = c_st_full;
                end else if (w_take) begin
                    w_state_nxt = c_st_empty;
                end
            end
            c_st_full: begin
                // in_ready is low here, so no accept can coincide.
                if (w_take) begin
                    w_shift     = 1'b1;
                    w_state_nxt = c_st_one;
                end
            end
            default: w_state_nxt = c_st_empty;
        endcase
        if (flush) begin
            w_state_nxt = c_st_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_empty;
            r_in_ready <= 1'b1;
            r_insn0    <= '0;
            r_sel0     <= '0;
            r_cls0     <= '0;
            r_ill0     <= 1'b0;
            r_insn1    <= '0;
            r_sel1     <= '0;
            r_cls1     <= '0;
            r_ill1     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != c_st_full);
            if (w_load0) begin
                r_insn0 <= in_insn;
                r_sel0  <= w_sel;
                r_cls0  <= w_cls;
                r_ill0  <= w_ill;
            end else if (w_shift) begin
                r_insn0 <= r_insn1;
                r_sel0  <= r_sel1;
                r_cls0  <= r_cls1;
                r_ill0  <= r_ill1;
            end
            if (w_load1) begin
                r_insn1 <= in_insn;
                r_sel1  <= w_sel;
                r_cls1  <= w_cls;
                r_ill1  <= w_ill;
            end
            // A take coincident with flush was still delivered downstream.
            if (w_take && r_ill0 && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = (r_state != c_st_empty);
    assign out_insn      = r_insn0;
    assign out_select    = r_sel0;
    assign out_class     = r_cls0;
    assign out_illegal   = r_ill0;
    assign illegal_count = r_cnt;

endmodule
`default_nettype wire
